// File: rtl/led_breathe.sv
// LED "breathing" driver: a triangle-ramped duty level feeds a free-running PWM compare.
// The level walks 0..MAX..0, holding each value for STEP_CYCLES clocks.
module led_breathe #(
    parameter int FREQ     = 0,
    parameter int PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                dir_o
);

    localparam int STEP_CYCLES = FREQ / (2 * ((1 << PWM_BITS) - 1));
    localparam int SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LVL   = '1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);

    if (FREQ == 0) begin : g_err_freq
        $error("led_breathe: FREQ must be nonzero");
    end
    if (PWM_BITS < 2 || PWM_BITS > 16) begin : g_err_bits
        $error("led_breathe: PWM_BITS must be in 2..16");
    end
    if (FREQ != 0 && STEP_CYCLES == 0) begin : g_err_step
        $error("led_breathe: FREQ too low, STEP_CYCLES evaluates to 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [SW-1:0]       step_q, step_d;
    logic                led_q, led_d;
    logic                tick;

    assign tick = (step_q == STEP_LAST);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        pwm_d   = pwm_q;
        step_d  = step_q;
        // LED compare uses the current registers, so it lags them by one clock.
        led_d   = (state_q != IDLE) && (pwm_q < level_q);

        case (state_q)
            IDLE: begin
                level_d = '0;
                pwm_d   = '0;
                step_d  = '0;
                if (en_i) begin
                    state_d = UP;
                end
            end
            default: begin
                if (!en_i) begin
                    // Disable wins over a coincident tick: no level update.
                    state_d = IDLE;
                    level_d = '0;
                    pwm_d   = '0;
                    step_d  = '0;
                end else begin
                    pwm_d  = pwm_q + 1'b1;
                    step_d = tick ? '0 : step_q + 1'b1;
                    if (tick) begin
                        if (state_q == UP) begin
                            level_d = level_q + 1'b1;
                            if (level_d == MAX_LVL) begin
                                state_d = DOWN;
                            end
                        end else begin
                            level_d = level_q - 1'b1;
                            if (level_d == '0) begin
                                state_d = UP;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            level_q <= '0;
            pwm_q   <= '0;
            step_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
            step_q  <= step_d;
            led_q   <= led_d;
        end
    end

    assign led_o   = led_q;
    assign level_o = level_q;
    assign dir_o   = (state_q != DOWN);

endmodule

// File: tb/tb_led_breathe.sv
// Randomized bench for led_breathe: a time-since-enable triangle model predicts level, direction and LED.
`timescale 1ns/1ps
module tb_led_breathe;

    localparam int FREQ     = 60;
    localparam int PWM_BITS = 2;
    localparam int MAXV     = (1 << PWM_BITS) - 1;
    localparam int PERIOD   = 1 << PWM_BITS;
    localparam int STEP     = FREQ / (2 * MAXV);
    localparam int NCYC     = 4000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                led;
    logic [PWM_BITS-1:0] level;
    logic                dir;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state: whether breathing is active and clocks elapsed since it began.
    bit m_active = 1'b0;
    int m_t      = 0;
    bit m_led    = 1'b0;

    led_breathe #(.FREQ(FREQ), .PWM_BITS(PWM_BITS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .led_o  (led),
        .level_o(level),
        .dir_o  (dir)
    );

    always #5 clk = ~clk;

    // Triangle wave: step k of the ramp, folded over a 2*MAX period.
    function automatic int ref_level(input int t);
        int p;
        p = (t / STEP) % (2 * MAXV);
        return (p <= MAXV) ? p : 2 * MAXV - p;
    endfunction

    function automatic int ref_dir(input int t);
        int p;
        p = (t / STEP) % (2 * MAXV);
        return (p < MAXV) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_led    = 1'b0;
        end else if (!m_active) begin
            m_led = 1'b0;
            if (en) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else begin
            m_led = ((m_t % PERIOD) < ref_level(m_t));
            if (!en) begin
                m_active = 1'b0;
                m_t      = 0;
            end else begin
                m_t++;
            end
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int lv, dv;
        lv = m_active ? ref_level(m_t) : 0;
        dv = m_active ? ref_dir(m_t) : 1;
        check_val("level", int'(level), lv);
        check_val("dir", int'(dir), dv);
        check_val("led", int'(led), int'(m_led));
    endtask

    // Drive for the next posedge, logging each change of control inputs as a transaction.
    task automatic drive(input logic r, input logic e);
        if (r !== rst_n || e !== en)
            $display("txn cycle=%0d rst_n=%0b en=%0b", cyc, r, e);
        rst_n = r;
        en    = e;
    endtask

    initial begin
        logic r, e;
        rst_n = 1'b0;
        en    = 1'b1;
        $display("txn cycle=0 rst_n=0 en=1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs();
        end
        for (int i = 0; i < NCYC; i++) begin
            if (i < 5) begin
                r = 1'b1; e = 1'b0;
            end else if (i < 200) begin
                r = 1'b1; e = 1'b1;              // several full sweeps
            end else if ((i % 500) < 30) begin
                r = ($urandom_range(0, 19) != 0);
                e = $urandom_range(0, 1) != 0;   // choppy enable window
            end else begin
                r = ($urandom_range(0, 299) != 0);
                e = ($urandom_range(0, 79) != 0);
            end
            drive(r, e);
            @(negedge clk);
            check_outputs();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_breathe.md
LED_BREATHE -- requirements
Module: led_breathe

Interface
REQ-001 SHALL have parameter FREQ, default 0, input clock frequency in Hz; FREQ = 0 SHALL raise an elaboration error.
REQ-002 SHALL have parameter PWM_BITS, default 8, width of the PWM counter and brightness level; legal range 2..16.
REQ-003 SHALL derive STEP_CYCLES = FREQ / (2*(2^PWM_BITS-1)), integer division; STEP_CYCLES = 0 SHALL raise an elaboration error.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_ni  input  1  synchronous, active-low reset.
REQ-006 en_i  input  1  breathing enable; low forces idle.
REQ-007 led_o  output  1  PWM-modulated LED drive, registered.
REQ-008 level_o  output  PWM_BITS  current duty level.
REQ-009 dir_o  output  1  ramp direction: 1 = up, 0 = down.

Function
REQ-010 SHALL implement FSM states IDLE, UP, DOWN; MAX = 2^PWM_BITS-1.
REQ-011 pwm_cnt (PWM_BITS wide) SHALL increment by 1 every clock while state != IDLE, wrap MAX->0, and hold 0 in IDLE.
REQ-012 step_cnt SHALL count 0..STEP_CYCLES-1 every clock while state != IDLE, wrap to 0, and assert internal tick when equal to STEP_CYCLES-1; held 0 in IDLE.
REQ-013 IDLE -> UP on the clock en_i is sampled high; level stays 0, counters start from 0 on that transition.
REQ-014 In UP, on tick: level <= level+1; if level+1 == MAX, state <= DOWN.
REQ-015 In DOWN, on tick: level <= level-1; if level-1 == 0, state <= UP.
REQ-016 Level sequence SHALL be 0,1,...,MAX,MAX-1,...,1,0,1,..., each value held exactly STEP_CYCLES clocks (first value 0 held STEP_CYCLES clocks after leaving IDLE); level never exceeds MAX nor goes below 0.
REQ-017 led_o SHALL be registered: led_o(n+1) = (state(n) != IDLE) AND (pwm_cnt(n) < level(n)).
REQ-018 Duty SHALL be level/2^PWM_BITS: level 0 -> led_o constantly 0; level MAX -> low 1 clock per 2^PWM_BITS.
REQ-019 level_o SHALL equal the level register; dir_o SHALL be 1 in IDLE and UP, 0 in DOWN.
REQ-020 en_i sampled low in UP or DOWN SHALL on that edge force state IDLE, level 0, pwm_cnt 0, step_cnt 0; led_o 0 from the next edge.
REQ-021 en_i low and tick on the same clock: en_i SHALL win (no level update).
REQ-022 Re-enable after IDLE SHALL restart the ramp from level 0, direction up, per REQ-013.

Reset
REQ-023 rst_ni sampled low SHALL set state IDLE, level 0, pwm_cnt 0, step_cnt 0, led_o 0, level_o 0, dir_o 1, regardless of en_i.
REQ-024 Reset SHALL take priority over en_i and tick; mid-operation reset SHALL behave as REQ-023, then REQ-013 on release with en_i high.

Verification (FREQ=60, PWM_BITS=2 -> MAX=3, STEP_CYCLES=10)
REQ-025 rst_ni low 3 clocks, en_i high -> led_o=0, level_o=0, dir_o=1 throughout and on the release edge.
REQ-026 en_i rises after reset -> level_o stays 0 for 10 clocks after entering UP, then 1; led_o stays 0 while level_o=0.
REQ-027 Full sweep -> level_o sequence 0,1,2,3,2,1,0,1, each 10 clocks; dir_o falls on the edge level_o becomes 3, rises on the edge it becomes 0.
REQ-028 Duty check -> over any 4 aligned clocks: level 1 -> led_o high 1; level 2 -> high 2; level 3 -> high 3.
REQ-029 en_i dropped while in DOWN at level 2 -> next edge level_o=0, dir_o=1, led_o=0 the edge after; re-raise -> REQ-026 behaviour repeats.
REQ-030 rst_ni pulsed low 1 clock at level 3 with en_i held high -> all outputs to reset values, then ramp restarts from 0 exactly as REQ-026.
